// File: rtl/exe_mem_req_unit.sv
// Execute-stage memory request unit: latches one load/store op, issues at most one
// req/addr_ok bus handshake for it, and hands a result record on to the MEM stage.
module exe_mem_req_unit #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int LSB_W  = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ld,
    input  logic              in_st,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_ex,
    input  logic              flush,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [STRB_W-1:0] wstrb,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_issued,
    output logic              out_ale,
    output logic [LSB_W-1:0]  out_lsb,
    output logic [1:0]        out_size,
    output logic              out_unsigned,
    output logic              discard_resp
);

    localparam logic [4:0] STRB_BYTES = 5'(STRB_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_CANCEL
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                issued_q, issued_d;
    logic                ale_q, ale_d;
    logic                unsigned_q, unsigned_d;

    logic                mem_op;
    logic                ale;
    logic                accept;
    logic [4:0]          size_bytes;
    logic [4:0]          size_mask;
    logic [7:0]          byte_mask;
    logic [STRB_W-1:0]   wstrb_new;
    logic [DATA_W-1:0]   wdata_rep;

    // Decode of the offered op: alignment check, byte strobes and lane-replicated data.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        mem_op     = in_ld | in_st;
        size_bytes = 5'd1 << in_size;
        size_mask  = size_bytes - 5'd1;
        ale        = mem_op & (((in_addr[2:0] & size_mask[2:0]) != 3'b000) |
                               (size_bytes > STRB_BYTES));
        case (in_size)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
        wstrb_new = in_st ? (STRB_W'(byte_mask) << in_addr[LSB_W-1:0]) : '0;
        wdata_rep = '0;
        // Byte lane i takes source byte (i mod access size), replicating the low bits.
        for (int i = 0; i < STRB_W; i++) begin
            wdata_rep[i*8 +: 8] = in_wdata[{3'(i) & size_mask[2:0], 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        issued_d     = issued_q;
        ale_d        = ale_q;
        unsigned_d   = unsigned_q;
        req          = 1'b0;
        out_valid    = 1'b0;
        discard_resp = 1'b0;

        in_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
        accept   = in_valid & in_ready;

        case (state_q)
            ST_REQ: begin
                req = 1'b1;
                if (addr_ok) begin
                    if (flush) begin
                        state_d      = ST_IDLE;
                        discard_resp = 1'b1;
                    end else begin
                        state_d  = ST_HOLD;
                        issued_d = 1'b1;
                    end
                end else if (flush) begin
                    state_d = ST_CANCEL;
                end
            end
            // The request already on the bus cannot be retracted; wait it out and drop its response.
            ST_CANCEL: begin
                req = 1'b1;
                if (addr_ok) begin
                    state_d      = ST_IDLE;
                    discard_resp = 1'b1;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // A new op overrides the HOLD->IDLE exit so back-to-back ops see no bubble.
        if (accept) begin
            state_d    = (mem_op & ~in_ex & ~ale) ? ST_REQ : ST_HOLD;
            wr_d       = in_st;
            size_d     = in_size;
            addr_d     = in_addr;
            wstrb_d    = wstrb_new;
            wdata_d    = wdata_rep;
            issued_d   = 1'b0;
            ale_d      = ale;
            unsigned_d = in_unsigned;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            issued_q   <= 1'b0;
            ale_q      <= 1'b0;
            unsigned_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            issued_q   <= issued_d;
            ale_q      <= ale_d;
            unsigned_q <= unsigned_d;
        end
    end

    assign wr           = wr_q;
    assign size         = size_q;
    assign addr         = addr_q;
    assign wstrb        = wstrb_q;
    assign wdata        = wdata_q;
    assign out_issued   = issued_q;
    assign out_ale      = ale_q;
    assign out_lsb      = addr_q[LSB_W-1:0];
    assign out_size     = size_q;
    assign out_unsigned = unsigned_q;

endmodule
